led_fade_driver: RTL

- Output stage directly downstream of the slow blink counter.
- Consumes the blink counter's 1-bit blink level and drives the board LEDs.
- Instead of hard on/off edges, LED brightness ramps up and down with PWM, producing a "breathing" blink.
- LEDG[0] carries the PWM-faded blink; LEDG[1] flags that a ramp is in progress.

---
 rtl/led_fade_driver.sv | 132 +++++++++++++
 1 files changed

// File: rtl/led_fade_driver.sv
// PWM "breathing" LED stage fed by the slow blink counter: LEDG[0] fades, LEDG[1] flags a ramp.
// Define LED_GAMMA_EN to drive the PWM comparator with a squared (gamma-corrected) duty.
module led_fade_driver #(
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned PRESCALE = 12207,
    parameter int unsigned STEP     = 1
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       blink_in,
    output logic [1:0] LEDG
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS:0]   STEP_EXT = (PWM_BITS + 1)'(STEP);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StRise = 2'd1,
        StOn   = 2'd2,
        StFall = 2'd3
    } state_e;

    logic                sync_q;
    logic                blink_s_q;
    logic [PRE_W-1:0]    pre_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] level_q;
    logic [1:0]          led_q;
    state_e              state_q;

    logic                tick;
    logic [PWM_BITS:0]   rise_sum;
    logic [PWM_BITS-1:0] rise_next;
    logic [PWM_BITS-1:0] fall_next;
    logic [PWM_BITS-1:0] duty;

    // Two-flop synchronizer; blink_in is asynchronous to CLOCK_50.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_q    <= 1'b0;
            blink_s_q <= 1'b0;
        end else begin
            sync_q    <= blink_in;
            blink_s_q <= sync_q;
        end
    end

    assign tick = (pre_cnt_q == PRE_LAST);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pre_cnt_q <= '0;
        end else if (tick) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
        end
    end

    // Ramp arithmetic saturates at both ends; the sum is one bit wider so it cannot wrap.
    assign rise_sum  = {1'b0, level_q} + STEP_EXT;
    assign rise_next = (rise_sum > {1'b0, MAX}) ? MAX : rise_sum[PWM_BITS-1:0];
    assign fall_next = ({1'b0, level_q} >= STEP_EXT) ? (level_q - STEP_EXT[PWM_BITS-1:0]) : '0;

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;
    assign level_sq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
    assign duty     = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty = level_q;
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StOff;
            level_q <= '0;
            led_q   <= 2'b00;
        end else begin
            led_q[0] <= (level_q == MAX) || (pwm_cnt_q < duty);
            led_q[1] <= (state_q == StRise) || (state_q == StFall);
            unique case (state_q)
                StOff: begin
                    level_q <= '0;
                    if (blink_s_q) begin
                        state_q <= StRise;
                    end
                end
                StRise: begin
                    // A reversal wins over a coincident tick; the level holds that cycle.
                    if (!blink_s_q) begin
                        state_q <= StFall;
                    end else if (tick) begin
                        level_q <= rise_next;
                        if (rise_next == MAX) begin
                            state_q <= StOn;
                        end
                    end
                end
                StOn: begin
                    level_q <= MAX;
                    if (!blink_s_q) begin
                        state_q <= StFall;
                    end
                end
                StFall: begin
                    if (blink_s_q) begin
                        state_q <= StRise;
                    end else if (tick) begin
                        level_q <= fall_next;
                        if (fall_next == '0) begin
                            state_q <= StOff;
                        end
                    end
                end
            endcase
        end
    end

    assign LEDG = led_q;

endmodule
